// File: rtl/pattern_seq_pkg.sv
// Shared types and default constants for the test-pattern sequencer.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  localparam int DEF_MIN_PATTERN = 1;
  localparam int DEF_MAX_PATTERN = 8;
  localparam int PATTERN_W       = 4;

endpackage

// File: rtl/frame_dwell_timer.sv
// Counts frame strobes while enabled. Expires on the strobe that completes a dwell period.
module frame_dwell_timer #(
  parameter int DWELL_FRAMES = 120
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [7:0] LAST_COUNT = 8'(DWELL_FRAMES - 1);

  logic [7:0] r_count;

  assign o_expire = i_enable && i_strobe && (r_count == LAST_COUNT);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && i_strobe) begin
      r_count <= o_expire ? 8'd0 : r_count + 8'd1;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector with OFF / MANUAL / AUTO modes.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int MIN_PATTERN  = DEF_MIN_PATTERN,
  parameter int MAX_PATTERN  = DEF_MAX_PATTERN,
  parameter int DWELL_FRAMES = 120
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_strobe,
  input  logic                 i_next,
  input  logic                 i_prev,
  input  logic                 i_enable,
  input  logic                 i_auto,
  output logic [PATTERN_W-1:0] o_pattern,
  output logic                 o_change,
  output logic                 o_auto_active
);

  localparam logic [PATTERN_W-1:0] P_MIN = PATTERN_W'(MIN_PATTERN);
  localparam logic [PATTERN_W-1:0] P_MAX = PATTERN_W'(MAX_PATTERN);

  state_t               r_state;
  logic [PATTERN_W-1:0] r_pattern;
  logic [PATTERN_W-1:0] r_saved;
  logic                 r_pend_valid;
  logic                 r_pend_up;
  logic                 r_change;
  logic                 r_auto_active;

  logic                 w_pend_valid;
  logic                 w_pend_up;
  logic                 w_apply;
  logic                 w_timer_en;
  logic                 w_timer_clear;
  logic                 w_expire;
  logic                 w_auto_adv;
  logic                 w_step_up;
  logic [PATTERN_W-1:0] w_stepped;

  function automatic logic [PATTERN_W-1:0] f_step(input logic [PATTERN_W-1:0] p,
                                                  input logic up);
    if (up) return (p == P_MAX) ? P_MIN : p + 1'b1;
    else    return (p == P_MIN) ? P_MAX : p - 1'b1;
  endfunction

  // Request seen this cycle merges with the held one; both at once cancels.
  always_comb begin
    w_pend_valid = r_pend_valid;
    w_pend_up    = r_pend_up;
    if (i_next && i_prev) begin
      w_pend_valid = 1'b0;
    end else if (i_next) begin
      w_pend_valid = 1'b1;
      w_pend_up    = 1'b1;
    end else if (i_prev) begin
      w_pend_valid = 1'b1;
      w_pend_up    = 1'b0;
    end
  end

  assign w_apply       = i_frame_strobe && i_enable && (r_state != ST_OFF) && w_pend_valid;
  assign w_timer_en    = (r_state == ST_AUTO) && i_enable && i_auto;
  assign w_timer_clear = (r_state != ST_AUTO) || w_apply ||
                         (i_frame_strobe && !(i_enable && i_auto));
  assign w_auto_adv    = w_expire && !w_pend_valid;
  assign w_step_up     = !w_pend_valid || w_pend_up;
  assign w_stepped     = f_step(r_pattern, w_step_up);

  frame_dwell_timer #(
    .DWELL_FRAMES(DWELL_FRAMES)
  ) u_dwell (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_frame_strobe),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_OFF;
      r_pattern     <= '0;
      r_saved       <= P_MIN;
      r_pend_valid  <= 1'b0;
      r_pend_up     <= 1'b0;
      r_change      <= 1'b0;
      r_auto_active <= 1'b0;
    end else begin
      r_change <= 1'b0;

      if (i_frame_strobe || (r_state == ST_OFF)) begin
        r_pend_valid <= 1'b0;
      end else begin
        r_pend_valid <= w_pend_valid;
        r_pend_up    <= w_pend_up;
      end

      if (i_frame_strobe) begin
        if (!i_enable) begin
          r_state       <= ST_OFF;
          r_auto_active <= 1'b0;
          if (r_state != ST_OFF) begin
            r_pattern <= '0;
            r_change  <= 1'b1;
          end
        end else begin
          r_state       <= i_auto ? ST_AUTO : ST_MANUAL;
          r_auto_active <= i_auto;
          if (r_state == ST_OFF) begin
            r_pattern <= r_saved;
            r_change  <= 1'b1;
          end else if (w_pend_valid || w_auto_adv) begin
            r_pattern <= w_stepped;
            r_saved   <= w_stepped;
            r_change  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_pattern     = r_pattern;
  assign o_change      = r_change;
  assign o_auto_active = r_auto_active;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter MIN_PATTERN, default 1, meaning lowest selectable test pattern index.
REQ-002 SHALL have parameter MAX_PATTERN, default 8, meaning highest selectable test pattern index.
REQ-003 SHALL have parameter DWELL_FRAMES, default 120, meaning frames per pattern in auto mode (legal range 1..255).
REQ-004 SHALL have port i_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_frame_strobe, input, 1, one-cycle pulse at frame start.
REQ-007 SHALL have port i_next, input, 1, one-cycle debounced request to step the pattern up.
REQ-008 SHALL have port i_prev, input, 1, one-cycle debounced request to step the pattern down.
REQ-009 SHALL have port i_enable, input, 1, level; low forces the generator off (pattern 0).
REQ-010 SHALL have port i_auto, input, 1, level; high selects auto-advance.
REQ-011 SHALL have port o_pattern, output, 4, pattern index driving the generator select.
REQ-012 SHALL have port o_change, output, 1, one-cycle pulse coincident with any o_pattern update.
REQ-013 SHALL have port o_auto_active, output, 1, high while the FSM is in AUTO.

Function
REQ-014 SHALL implement FSM states OFF, MANUAL and AUTO, and all state and o_pattern changes SHALL occur only on cycles where i_frame_strobe=1.
REQ-015 SHALL, at a strobe, transition: any state with i_enable=0 -> OFF; OFF with i_enable=1 -> AUTO if i_auto=1, else MANUAL; MANUAL/AUTO follow i_auto.
REQ-016 SHALL drive o_pattern=0 in OFF and restore a saved last pattern (initially MIN_PATTERN) on leaving OFF.
REQ-017 SHALL latch i_next/i_prev into a one-entry pending request (direction +1/-1), last request wins, and repeated requests in a frame yield one step only.
REQ-018 SHALL cancel the pending request when i_next and i_prev are both asserted in the same cycle.
REQ-019 SHALL apply a request arriving on the same cycle as i_frame_strobe at that strobe.
REQ-020 SHALL, at a strobe in MANUAL or AUTO with a pending request, step o_pattern by ±1 with wrap MAX_PATTERN+1 -> MIN_PATTERN and MIN_PATTERN-1 -> MAX_PATTERN, clear the pending request and zero the dwell counter.
REQ-021 SHALL, in AUTO, increment an 8-bit dwell counter on each strobe; when the counter equals DWELL_FRAMES-1 at a strobe with no pending request, advance +1 (wrapping) and zero the counter.
REQ-022 SHALL give manual requests priority over auto advance at the same strobe.
REQ-023 SHALL discard requests while in OFF, and on an OFF -> MANUAL/AUTO strobe.
REQ-024 SHALL register o_pattern, updating it in the cycle after the qualifying strobe (latency 1), and assert o_change in that same cycle, including entry to and exit from OFF.
REQ-025 SHALL hold the dwell counter at 0 outside AUTO.

Reset
REQ-026 SHALL, while i_rst=1, set state=OFF, o_pattern=0, saved pattern=MIN_PATTERN, pending cleared, dwell counter=0, o_change=0, o_auto_active=0.
REQ-027 SHALL let i_rst override all other inputs, including a simultaneous strobe or request, and discard any mid-frame pending request.

Structure
REQ-028 SHALL place the FSM state encoding and the default MIN/MAX pattern constants in the shared package pattern_seq_pkg.
REQ-029 SHALL implement the strobe-counted dwell counter as the sub-module frame_dwell_timer (inputs strobe, clear, enable; output expire).

Verification
REQ-030 SHALL cover: reset, i_enable=1, i_auto=0, one strobe -> o_pattern=1 one cycle after the strobe, with o_change pulsed once.
REQ-031 SHALL cover: MANUAL at 8, three i_next pulses then a strobe -> o_pattern=1 (single step with wrap); at 1, i_prev then a strobe -> 8.
REQ-032 SHALL cover: i_next and i_prev in the same cycle, then a strobe -> o_pattern unchanged and o_change=0.
REQ-033 SHALL cover: AUTO with DWELL_FRAMES=3, starting at 5 -> o_pattern 6 after the 3rd strobe and 7 after the 6th; an i_prev before the 2nd strobe -> 4 after it, with the counter restarted.
REQ-034 SHALL cover: at pattern 6, i_enable=0 at a strobe -> 0; i_enable=1 at the next strobe -> 6; an i_next issued while OFF is ignored.
REQ-035 SHALL cover: i_rst asserted on the same cycle as a strobe with a pending request -> o_pattern=0, state OFF, no o_change.
